// File: rtl/memory_data_pkg.sv
// Shared constants and clear-engine state encoding for the data memory bank.
package memory_data_pkg;

    // Same-address read-during-write policy selectors.
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Clear engine states, kept as plain constants for legacy compatibility.
    typedef logic [0:0] clr_state_t;
    localparam clr_state_t IDLE  = 1'b0;
    localparam clr_state_t CLEAR = 1'b1;

endpackage

// File: rtl/memory_data_clr_fsm.sv
// Clear engine: walks ptr over every word once, asking the array to write zero.
module memory_data_clr_fsm
    import memory_data_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int INIT_CLR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    // Set by reset when INIT_CLR is on, so the first edge after release starts a clear.
    logic              pend_q, pend_d;

    // Next-state: start on request or pending init clear, stop after the last word.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (clr_req || pend_q) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            CLEAR: begin
                // Terminal test on the last address, not on counter wrap.
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any clear in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            pend_q  <= (INIT_CLR != 0);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/memory_data_bank.sv
// Parametrised single-port data memory with byte lanes, 1/2-cycle reads and a clear engine.
module memory_data_bank
    import memory_data_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0,
    parameter int INIT_CLR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    input  logic                clr_req,
    output logic [DATA_W-1:0]   q,
    output logic                q_valid,
    output logic                busy
);

    localparam int NLANES = DATA_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
        $error("memory_data_bank: DATA_W must be a positive multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("memory_data_bank: RD_LAT must be 1 or 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_acc, user_wr, user_rd;
    logic [DATA_W-1:0] rd_word, wr_word, rdw_word;
    logic [DATA_W-1:0] q1_q;
    logic              v1_q;

    memory_data_clr_fsm #(
        .ADDR_W   (ADDR_W),
        .INIT_CLR (INIT_CLR)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign user_acc = ce & ~busy;
    assign user_wr  = user_acc & we;
    assign user_rd  = user_acc & ~we;

    // Byte-lane merge of write data over the currently stored word.
    always_comb begin
        rd_word = mem[addr];
        wr_word = rd_word;
        for (int i = 0; i < NLANES; i++) begin
            if (be[i]) begin
                wr_word[8*i +: 8] = data[8*i +: 8];
            end
        end
    end

    assign rdw_word = (RDW_MODE == RDW_WRITE_FIRST && we) ? wr_word : rd_word;

    // Array write port: the clear engine owns the port while busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_wr) begin
            mem[addr] <= wr_word;
        end
    end

    // First read stage: registered array read; holds when no user access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= user_rd;
            if (user_acc) begin
                q1_q <= rdw_word;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] q2_q;
        logic              v2_q;
        logic              u1_q;

        // Second read stage: only advances when stage one took a new word.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q2_q <= '0;
                v2_q <= 1'b0;
                u1_q <= 1'b0;
            end else begin
                u1_q <= user_acc;
                v2_q <= v1_q;
                if (u1_q) begin
                    q2_q <= q1_q;
                end
            end
        end

        assign q       = q2_q;
        assign q_valid = v2_q;
    end else begin : g_lat1
        assign q       = q1_q;
        assign q_valid = v1_q;
    end

endmodule

// File: tb/tb_memory_data_bank.sv
// Directed bench: instance a is 8x128 read-first 1-cycle, instance b is 32x16 write-first 2-cycle.
module tb_memory_data_bank;

    logic        clk = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Instance a: DATA_W=8, ADDR_W=7, RD_LAT=1, RDW_MODE=0, INIT_CLR=1.
    logic        rst_a, ce_a, we_a, clr_a, qv_a, busy_a;
    logic [0:0]  be_a;
    logic [6:0]  addr_a;
    logic [7:0]  data_a, q_a;

    // Instance b: DATA_W=32, ADDR_W=4, RD_LAT=2, RDW_MODE=1, INIT_CLR=1.
    logic        rst_b, ce_b, we_b, clr_b, qv_b, busy_b;
    logic [3:0]  be_b;
    logic [3:0]  addr_b;
    logic [31:0] data_b, q_b;

    always #5 clk = ~clk;

    memory_data_bank #(
        .DATA_W(8), .ADDR_W(7), .RD_LAT(1), .RDW_MODE(0), .INIT_CLR(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .ce(ce_a), .we(we_a), .be(be_a), .addr(addr_a),
        .data(data_a), .clr_req(clr_a), .q(q_a), .q_valid(qv_a), .busy(busy_a)
    );

    memory_data_bank #(
        .DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1), .INIT_CLR(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .ce(ce_b), .we(we_b), .be(be_b), .addr(addr_b),
        .data(data_b), .clr_req(clr_b), .q(q_b), .q_valid(qv_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ce_a = 1'b0; we_a = 1'b0; be_a = 1'b1; clr_a = 1'b0;
    endtask

    task automatic idle_b();
        ce_b = 1'b0; we_b = 1'b0; be_b = 4'hf; clr_b = 1'b0;
    endtask

    task automatic set_a(input logic w, input logic [6:0] a, input logic [7:0] d,
                         input logic [0:0] b);
        ce_a = 1'b1; we_a = w; addr_a = a; data_a = d; be_a = b;
    endtask

    task automatic set_b(input logic w, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] b);
        ce_b = 1'b1; we_b = w; addr_b = a; data_b = d; be_b = b;
    endtask

    task automatic test_reset();
        int na, nb;
        rst_a = 1'b1; rst_b = 1'b1;
        idle_a(); idle_b();
        addr_a = '0; data_a = '0; addr_b = '0; data_b = '0;
        #3;
        checks++;
        if (q_a !== 8'h00 || qv_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: q=%h qv=%b busy=%b, want 00/0/0", q_a, qv_a, busy_a);
        end
        checks++;
        if (q_b !== 32'h0 || qv_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: q=%h qv=%b busy=%b, want 0/0/0", q_b, qv_b, busy_b);
        end
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL init_clear_start: busy_a=%b busy_b=%b, want 1/1", busy_a, busy_b);
        end
        na = 0; nb = 0;
        while ((busy_a || busy_b) && na < 1000) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            tick();
        end
        checks++;
        if (na !== 128 || nb !== 16) begin
            errors++;
            $display("FAIL init_clear_len: a=%0d b=%0d, want 128/16", na, nb);
        end
    endtask

    task automatic test_basic_rw();
        logic [7:0] exp [4];
        exp[0] = 8'h12; exp[1] = 8'h34; exp[2] = 8'h56; exp[3] = 8'h21;
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 7'(i), exp[i], 1'b1);
            tick();
        end
        // ce low must block a write.
        ce_a = 1'b0; we_a = 1'b1; addr_a = 7'd0; data_a = 8'hff;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_a(1'b0, 7'(i), 8'h00, 1'b1);
            tick();
            checks++;
            if (q_a !== exp[i] || qv_a !== 1'b1) begin
                errors++;
                $display("FAIL read_a[%0d]: q=%h qv=%b, want %h/1", i, q_a, qv_a, exp[i]);
            end
        end
        idle_a();
        tick();
        checks++;
        if (q_a !== 8'h21 || qv_a !== 1'b0) begin
            errors++;
            $display("FAIL hold_a: q=%h qv=%b, want 21/0", q_a, qv_a);
        end
    endtask

    task automatic test_rdw_read_first();
        set_a(1'b1, 7'd4, 8'h24, 1'b1);
        tick();
        set_a(1'b1, 7'd4, 8'h99, 1'b1);
        tick();
        checks++;
        if (q_a !== 8'h24 || qv_a !== 1'b0) begin
            errors++;
            $display("FAIL rdw_read_first: q=%h qv=%b, want 24/0", q_a, qv_a);
        end
        // Write with no lanes enabled leaves the word alone.
        set_a(1'b1, 7'd4, 8'h55, 1'b0);
        tick();
        checks++;
        if (q_a !== 8'h99 || qv_a !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_a: q=%h qv=%b, want 99/0", q_a, qv_a);
        end
        set_a(1'b0, 7'd4, 8'h00, 1'b1);
        tick();
        checks++;
        if (q_a !== 8'h99 || qv_a !== 1'b1) begin
            errors++;
            $display("FAIL readback_4: q=%h qv=%b, want 99/1", q_a, qv_a);
        end
        idle_a();
        tick();
    endtask

    task automatic test_byte_lanes();
        set_b(1'b1, 4'd5, 32'haabbccdd, 4'hf);
        tick();
        set_b(1'b1, 4'd5, 32'h11223344, 4'b0101);
        tick();
        set_b(1'b0, 4'd5, 32'h0, 4'hf);
        tick();
        idle_b();
        tick();
        checks++;
        if (q_b !== 32'haa22cc44 || qv_b !== 1'b1) begin
            errors++;
            $display("FAIL byte_lanes: q=%h qv=%b, want aa22cc44/1", q_b, qv_b);
        end
        tick();
    endtask

    task automatic test_rdw_write_first();
        set_b(1'b1, 4'd4, 32'h24, 4'hf);
        tick();
        set_b(1'b1, 4'd4, 32'h99, 4'hf);
        tick();
        idle_b();
        tick();
        checks++;
        if (q_b !== 32'h99 || qv_b !== 1'b0) begin
            errors++;
            $display("FAIL rdw_write_first: q=%h qv=%b, want 99/0", q_b, qv_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp[0] = 32'h0a0b0c0d; exp[1] = 32'h10203040; exp[2] = 32'hdeadbeef;
        for (int i = 0; i < 3; i++) begin
            set_b(1'b1, 4'(i), exp[i], 4'hf);
            tick();
        end
        idle_b();
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            set_b(1'b0, 4'(i), 32'h0, 4'hf);
            tick();
            if (i == 0) begin
                checks++;
                if (qv_b !== 1'b0) begin
                    errors++;
                    $display("FAIL lat2_early: qv=%b, want 0", qv_b);
                end
            end else begin
                checks++;
                if (q_b !== exp[i-1] || qv_b !== 1'b1) begin
                    errors++;
                    $display("FAIL lat2_rd[%0d]: q=%h qv=%b, want %h/1", i-1, q_b, qv_b,
                             exp[i-1]);
                end
            end
        end
        idle_b();
        tick();
        checks++;
        if (q_b !== exp[2] || qv_b !== 1'b1) begin
            errors++;
            $display("FAIL lat2_rd[2]: q=%h qv=%b, want %h/1", q_b, qv_b, exp[2]);
        end
        tick();
        checks++;
        if (q_b !== exp[2] || qv_b !== 1'b0) begin
            errors++;
            $display("FAIL lat2_tail: q=%h qv=%b, want %h/0", q_b, qv_b, exp[2]);
        end
    endtask

    task automatic test_clear();
        int n;
        logic [6:0] raddr [3];
        raddr[0] = 7'd0; raddr[1] = 7'd10; raddr[2] = 7'd127;
        set_a(1'b1, 7'd10, 8'h3c, 1'b1);
        tick();
        set_a(1'b1, 7'd127, 8'hee, 1'b1);
        tick();
        // Read issued on the same edge as the clear request must still complete.
        set_a(1'b0, 7'd127, 8'h00, 1'b1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        checks++;
        if (q_a !== 8'hee || qv_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL clr_inflight: q=%h qv=%b busy=%b, want ee/1/1", q_a, qv_a, busy_a);
        end
        set_a(1'b1, 7'd10, 8'h77, 1'b1);
        n = 0;
        while (busy_a && n < 1000) begin
            n++;
            if (n == 5) clr_a = 1'b1;
            if (n == 50) set_a(1'b0, 7'd127, 8'h00, 1'b1);
            if (n == 100) set_a(1'b1, 7'd10, 8'h77, 1'b1);
            tick();
            idle_a();
            if (n == 50) begin
                checks++;
                if (qv_a !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_read: qv=%b, want 0", qv_a);
                end
            end
        end
        checks++;
        if (n !== 128) begin
            errors++;
            $display("FAIL clr_len: busy cycles=%0d, want 128", n);
        end
        for (int i = 0; i < 3; i++) begin
            set_a(1'b0, raddr[i], 8'h00, 1'b1);
            tick();
            checks++;
            if (q_a !== 8'h00 || qv_a !== 1'b1) begin
                errors++;
                $display("FAIL cleared[%0d]: q=%h qv=%b, want 00/1", raddr[i], q_a, qv_a);
            end
        end
        idle_a();
        tick();
    endtask

    task automatic test_rst_mid_clear();
        int n;
        set_a(1'b1, 7'd1, 8'h5a, 1'b1);
        tick();
        set_a(1'b0, 7'd1, 8'h00, 1'b1);
        tick();
        idle_a();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        n = 0;
        while (busy_a && n < 50) begin
            n++;
            tick();
        end
        rst_a = 1'b1;
        #1;
        checks++;
        if (q_a !== 8'h00 || qv_a !== 1'b0 || busy_a !== 1'b0 || n !== 50) begin
            errors++;
            $display("FAIL rst_mid_clear: q=%h qv=%b busy=%b n=%0d, want 00/0/0/50",
                     q_a, qv_a, busy_a, n);
        end
        tick(); tick();
        rst_a = 1'b0;
        tick();
        n = 0;
        while (busy_a && n < 1000) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 128) begin
            errors++;
            $display("FAIL reclear_len: busy cycles=%0d, want 128", n);
        end
        set_a(1'b0, 7'd1, 8'h00, 1'b1);
        tick();
        checks++;
        if (q_a !== 8'h00 || qv_a !== 1'b1) begin
            errors++;
            $display("FAIL reclear_data: q=%h qv=%b, want 00/1", q_a, qv_a);
        end
        idle_a();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_rdw_read_first();
        test_byte_lanes();
        test_rdw_write_first();
        test_back_to_back();
        test_clear();
        test_rst_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
